match_scheduler: RTL
====================

# match_scheduler

Lossless scheduler between the per-lane note matchers and the scorer. Every note match is held in a per-slot pending entry rather than lost when several slots fire in one cycle. Pending entries are issued one per handshake, round-robin, with the absolute timing error already computed. Each issue is presented to the scorer on a valid/ready interface.

## Interface
- N_SLOTS, 37: number of matcher slots.
- TIME_W, 16: width of song time and match times.
- STALE_LIMIT, 16'd200: age limit in song-time units for stale purge. Used only when MATCH_SCHED_STALE_EN is defined.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- song_time  in  TIME_W  current song time.
- match_trigger  in  N_SLOTS  one-cycle pulse per slot that matched.
- match_time  in  N_SLOTS*TIME_W  slot k's note time is in bits [k*TIME_W +: TIME_W].
- match_ready  in  1  scorer accepts the current issue.
- match_en  out  1  issue valid.
- match_dt  out  TIME_W  absolute timing error of the issue.
- match_slot  out  6  index of the issued slot.
- pending  out  N_SLOTS  per-slot pending flags.
- drop_count  out  8  saturating count of discarded matches.

## Operation
- Per slot, the block stores a pending bit and a TIME_W note time.
  - A trigger on a non-pending slot sets its pending bit and captures match_time[k].
  - A trigger on an already-pending slot that is not granted this cycle is dropped: drop_count increments and saturates at 255.
- Output FSM, with match_en as the state bit:
  - IDLE: match_en=0.
  - HOLD: match_en=1.
  - IDLE→HOLD when any slot is pending.
  - HOLD stays in HOLD while match_ready=0. While holding, match_dt and match_slot stay frozen.
  - HOLD with match_ready=1: the output reloads with a new grant in the same cycle if any slot is pending; otherwise HOLD→IDLE.
- Grant is permitted in IDLE, or in HOLD when match_ready=1.
  - The granted slot is the lowest pending index ≥ rr_ptr, wrapping from N_SLOTS-1 to 0.
  - After a grant, rr_ptr = granted+1, with N_SLOTS-1 wrapping to 0.
  - A grant clears the slot's pending bit, loads match_slot, and loads match_dt = |song_time − stored_time| using the song_time of the grant cycle. The unsigned difference takes the larger operand minus the smaller and has no wrap handling.
- Simultaneous trigger and grant on the same slot: the grant issues the old time. The new trigger then sets pending again with the new time. This is not a drop.
- Triggers on slots that are not pending never block or delay a grant.

## Timing
- Reset, asynchronous and effective immediately:
  - match_en=0, match_dt=0, match_slot=0.
  - pending=0, all stored times 0.
  - rr_ptr=0, drop_count=0, FSM in IDLE.
  - A reset in HOLD discards the issue and every pending entry.
- A trigger at edge t makes pending visible after t.
- Earliest issue: match_en=1 after edge t+1, i.e. 2-cycle latency from trigger to valid.
- Throughput: one issue per cycle while match_ready stays high and entries remain pending.
- A drop is counted at the edge on which the trigger is sampled.

## Configuration
- MATCH_SCHED_STALE_EN defined:
  - Each cycle, any pending slot that is not granted that cycle is purged when |song_time − stored_time| > STALE_LIMIT.
  - A purge clears the pending bit and increments drop_count, saturating.
  - A purge and a new trigger on the same slot in the same cycle: the trigger wins and no drop is counted.
- Not defined: no purge logic; entries wait indefinitely; STALE_LIMIT is ignored.

## Test plan
- Slot 5 triggers alone, time 1000, song_time 1010, match_ready=1 → match_en=1 two cycles later, match_slot=5, match_dt=10, then IDLE.
- Slots 0, 3 and 36 trigger in the same cycle, match_ready=1 → issued on three consecutive cycles in order 0, 3, 36; drop_count=0.
- match_ready=0 for 5 cycles with slot 2 pending → match_en stays 1 with match_dt and match_slot constant; slot 2 re-triggers → drop_count=1.
- rr_ptr=36; slots 36 and 1 pending → issued in order 36, then 1, exercising wrap.
- Same-cycle grant and re-trigger of slot 7: old time 500, new time 600, song_time 550 → issue dt=50; slot 7 pending again; next issue dt equals |song_time at that grant − 600|.
- With MATCH_SCHED_STALE_EN: slot 4 pending at time 100, match_ready=0, song_time reaches 301 → slot 4 pending clears and drop_count=1. Without the macro, slot 4 stays pending.

Source files
------------

// File: rtl/match_scheduler.sv
// match_scheduler
//
// Lossless scheduler between the per-lane note matchers and the scorer.
// Each slot owns a pending bit and a captured note time, so simultaneous
// matches are queued instead of lost. Pending entries are issued one per
// handshake in round-robin order, with the absolute timing error already
// computed against the song time of the grant cycle.
//
// Optional feature (macro MATCH_SCHED_STALE_EN):
//   When defined, pending entries whose age exceeds STALE_LIMIT are purged
//   and counted as drops. When undefined, entries wait indefinitely.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   song_time     current song time
//   match_trigger one-cycle match pulse per slot
//   match_time    slot k note time in [k*TIME_W +: TIME_W]
//   match_ready   scorer accepts the current issue
//   match_en      issue valid
//   match_dt      |song_time - note time| of the issue
//   match_slot    index of the issued slot
//   pending       per-slot pending flags
//   drop_count    saturating count of discarded matches
//
// Output FSM:
//   state | meaning
//   IDLE  | no issue presented (match_en = 0)
//   HOLD  | issue presented, waiting for match_ready (match_en = 1)

module match_scheduler #(
    parameter int                N_SLOTS     = 37,
    parameter int                TIME_W      = 16,
    parameter logic [TIME_W-1:0] STALE_LIMIT = TIME_W'(200)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TIME_W-1:0]         song_time,
    input  logic [N_SLOTS-1:0]        match_trigger,
    input  logic [N_SLOTS*TIME_W-1:0] match_time,
    input  logic                      match_ready,
    output logic                      match_en,
    output logic [TIME_W-1:0]         match_dt,
    output logic [5:0]                match_slot,
    output logic [N_SLOTS-1:0]        pending,
    output logic [7:0]                drop_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [TIME_W-1:0]  stored_time [N_SLOTS];
    logic [5:0]         rr_ptr;

    logic               any_pending;
    logic               grant_valid;
    logic [5:0]         grant_idx;
    logic [5:0]         hi_idx;
    logic [5:0]         lo_idx;
    logic               hi_found;
    logic [TIME_W-1:0]  grant_dt;
    logic [N_SLOTS-1:0] granted_vec;
    logic [N_SLOTS-1:0] stale_vec;
    logic [N_SLOTS-1:0] pending_nxt;
    logic [N_SLOTS-1:0] capture;
    logic [N_SLOTS-1:0] drop_vec;
    logic [5:0]         drop_n;
    logic [8:0]         drop_sum;

    function automatic logic [TIME_W-1:0] abs_diff(input logic [TIME_W-1:0] a,
                                                   input logic [TIME_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Round-robin pick: lowest pending index at or above rr_ptr, otherwise
    // the lowest pending index overall (the wrap case). Scanning downward
    // leaves the lowest match in each candidate without needing a break.
    always_comb begin
        hi_found    = 1'b0;
        hi_idx      = '0;
        lo_idx      = '0;
        any_pending = 1'b0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                any_pending = 1'b1;
                lo_idx      = 6'(k);
                if (6'(k) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = 6'(k);
                end
            end
        end
        grant_idx   = hi_found ? hi_idx : lo_idx;
        grant_valid = any_pending && ((state == IDLE) || match_ready);
        grant_dt    = abs_diff(song_time, stored_time[grant_idx]);
        granted_vec = grant_valid ? (N_SLOTS'(1) << grant_idx) : '0;
    end

`ifdef MATCH_SCHED_STALE_EN
    always_comb begin
        stale_vec = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            stale_vec[k] = pending[k] && !granted_vec[k] &&
                           (abs_diff(song_time, stored_time[k]) > STALE_LIMIT);
        end
    end
`else
    assign stale_vec = '0;
`endif

    // Per-slot next state. A grant reads the old stored time this cycle, so
    // a trigger on the slot being granted simply re-arms it with the new time.
    // A trigger also wins over a same-cycle stale purge, with nothing dropped.
    always_comb begin
        pending_nxt = pending & ~granted_vec;
        capture     = '0;
        drop_vec    = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (match_trigger[k]) begin
                if (pending[k] && !granted_vec[k] && !stale_vec[k]) begin
                    drop_vec[k] = 1'b1;
                end else begin
                    pending_nxt[k] = 1'b1;
                    capture[k]     = 1'b1;
                end
            end else if (stale_vec[k]) begin
                pending_nxt[k] = 1'b0;
                drop_vec[k]    = 1'b1;
            end
        end
    end

    // Several slots can drop in the same cycle, so add the whole count.
    always_comb begin
        drop_n = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            drop_n = drop_n + 6'(drop_vec[k]);
        end
        drop_sum = 9'(drop_count) + 9'(drop_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            match_dt   <= '0;
            match_slot <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            for (int k = 0; k < N_SLOTS; k++) begin
                stored_time[k] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            for (int k = 0; k < N_SLOTS; k++) begin
                if (capture[k]) begin
                    stored_time[k] <= match_time[k*TIME_W +: TIME_W];
                end
            end
            drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];

            if (grant_valid) begin
                state      <= HOLD;
                match_slot <= grant_idx;
                match_dt   <= grant_dt;
                rr_ptr     <= (grant_idx == 6'(N_SLOTS - 1)) ? 6'd0 : grant_idx + 6'd1;
            end else if ((state == HOLD) && match_ready) begin
                state <= IDLE;
            end
        end
    end

    assign match_en = (state == HOLD);

endmodule
